// File: rtl/ram_share_ctrl.sv
// ram_share_ctrl: shares one single-port synchronous RAM between requesters A and B.
// Round-robin arbitration; each access returns its result one cycle after grant.
// Optional post-reset clear sweep is compiled in with `define RAM_CLEAR_EN.

module ram_share_ctrl #(
   parameter int unsigned DEPTH  = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 3
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              a_req_i,
   input  logic              a_wren_i,
   input  logic [ADDR_W-1:0] a_addr_i,
   input  logic [DATA_W-1:0] a_data_i,
   output logic              a_gnt_o,
   output logic              a_valid_o,
   output logic [DATA_W-1:0] a_q_o,
   input  logic              b_req_i,
   input  logic              b_wren_i,
   input  logic [ADDR_W-1:0] b_addr_i,
   input  logic [DATA_W-1:0] b_data_i,
   output logic              b_gnt_o,
   output logic              b_valid_o,
   output logic [DATA_W-1:0] b_q_o,
   output logic [ADDR_W-1:0] ram_address_o,
   output logic [DATA_W-1:0] ram_data_o,
   output logic              ram_wren_o,
   input  logic [DATA_W-1:0] ram_q_i,
   output logic              busy_o
);

   if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
      $error("DEPTH must equal 2**ADDR_W");
   end

   logic              clearing;
   logic [ADDR_W-1:0] clr_addr;

`ifdef RAM_CLEAR_EN
   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

   typedef enum logic [0:0] {StClear, StServe} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

   // Sweep counter walks every address once, then hands over to normal service.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      if (state_q == StClear) begin
         if (clr_cnt_q == LastAddr) begin
            state_d = StServe;
         end else begin
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
         end
      end
   end

   // FSM state and sweep counter; reset restarts the sweep at address 0.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q   <= StClear;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   assign clearing = (state_q == StClear);
   assign clr_addr = clr_cnt_q;
`else
   assign clearing = 1'b0;
   assign clr_addr = '0;
`endif

   assign busy_o = clearing;

   logic              ptr_q, ptr_d;  // 0 = A has priority, 1 = B has priority
   logic              a_valid_q, b_valid_q;
   logic [DATA_W-1:0] a_q_q, b_q_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;

   // Arbitration and RAM drive; reset suppresses any grant in the same cycle.
   always_comb begin
      a_gnt_o       = 1'b0;
      b_gnt_o       = 1'b0;
      ram_wren_o    = 1'b0;
      ram_address_o = addr_q;
      ram_data_o    = data_q;
      ptr_d         = ptr_q;
      if (reset_i) begin
         ptr_d = 1'b0;
      end else if (clearing) begin
         ram_wren_o    = 1'b1;
         ram_address_o = clr_addr;
         ram_data_o    = '0;
      end else if (a_req_i && (!b_req_i || !ptr_q)) begin
         a_gnt_o       = 1'b1;
         ram_wren_o    = a_wren_i;
         ram_address_o = a_addr_i;
         ram_data_o    = a_data_i;
         ptr_d         = 1'b1;
      end else if (b_req_i) begin
         b_gnt_o       = 1'b1;
         ram_wren_o    = b_wren_i;
         ram_address_o = b_addr_i;
         ram_data_o    = b_data_i;
         ptr_d         = 1'b0;
      end
   end

   // RAM output is already registered, so q passes it through while valid and holds otherwise.
   assign a_valid_o = a_valid_q;
   assign b_valid_o = b_valid_q;
   assign a_q_o     = a_valid_q ? ram_q_i : a_q_q;
   assign b_q_o     = b_valid_q ? ram_q_i : b_q_q;

   // Pointer, valid pipeline, held results and last RAM address/data.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         ptr_q     <= 1'b0;
         a_valid_q <= 1'b0;
         b_valid_q <= 1'b0;
         a_q_q     <= '0;
         b_q_q     <= '0;
         addr_q    <= '0;
         data_q    <= '0;
      end else begin
         ptr_q     <= ptr_d;
         a_valid_q <= a_gnt_o;
         b_valid_q <= b_gnt_o;
         a_q_q     <= a_q_o;
         b_q_q     <= b_q_o;
         addr_q    <= ram_address_o;
         data_q    <= ram_data_o;
      end
   end

endmodule

// File: tb/tb_ram_share_ctrl.sv
// Directed self-checking bench for ram_share_ctrl with a behavioural 32x3 RAM.
// Adapts to RAM_CLEAR_EN being defined or not.

module tb_ram_share_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       a_req, a_wren, b_req, b_wren;
   logic [4:0] a_addr, b_addr;
   logic [2:0] a_data, b_data;
   logic       a_gnt, a_valid, b_gnt, b_valid;
   logic [2:0] a_q, b_q;
   logic [4:0] ram_address;
   logic [2:0] ram_data, ram_q;
   logic       ram_wren, busy;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   ram_share_ctrl #(.DEPTH(32), .ADDR_W(5), .DATA_W(3)) dut (
      .clock_i      (clk),
      .reset_i      (reset),
      .a_req_i      (a_req),
      .a_wren_i     (a_wren),
      .a_addr_i     (a_addr),
      .a_data_i     (a_data),
      .a_gnt_o      (a_gnt),
      .a_valid_o    (a_valid),
      .a_q_o        (a_q),
      .b_req_i      (b_req),
      .b_wren_i     (b_wren),
      .b_addr_i     (b_addr),
      .b_data_i     (b_data),
      .b_gnt_o      (b_gnt),
      .b_valid_o    (b_valid),
      .b_q_o        (b_q),
      .ram_address_o(ram_address),
      .ram_data_o   (ram_data),
      .ram_wren_o   (ram_wren),
      .ram_q_i      (ram_q),
      .busy_o       (busy)
   );

   // Behavioural single-port RAM: registered output, write-through.
   logic [2:0] mem [32];
   always @(posedge clk) begin
      if (ram_wren) begin
         mem[ram_address] <= ram_data;
         ram_q            <= ram_data;
      end else begin
         ram_q <= mem[ram_address];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic idle_inputs;
      a_req = 0; a_wren = 0; a_addr = 0; a_data = 0;
      b_req = 0; b_wren = 0; b_addr = 0; b_data = 0;
   endtask

   // Two reset cycles, release, then (with clear) wait out the sweep.
   task automatic do_reset;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
`ifdef RAM_CLEAR_EN
      for (int i = 0; i < 32; i++) tick();
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      #1;
      check("rst a_gnt", a_gnt, 0);
      check("rst b_gnt", b_gnt, 0);
      check("rst a_valid", a_valid, 0);
      check("rst b_valid", b_valid, 0);
      check("rst ram_wren", ram_wren, 0);
      check("rst a_q", a_q, 0);
      check("rst b_q", b_q, 0);
      check("rst ram_address", ram_address, 0);
      check("rst ram_data", ram_data, 0);
      tick();
      reset = 1'b0;

`ifdef RAM_CLEAR_EN
      // Sweep: requests are ignored for 32 cycles.
      a_req = 1; a_wren = 0; a_addr = 7;
      for (int i = 0; i < 32; i++) begin
         #1;
         check("sweep busy", busy, 1);
         check("sweep ram_wren", ram_wren, 1);
         check("sweep ram_address", ram_address, i);
         check("sweep ram_data", ram_data, 0);
         check("sweep a_gnt", a_gnt, 0);
         tick();
      end
      #1;
      check("post-sweep busy", busy, 0);
      check("read7 a_gnt", a_gnt, 1);
      check("read7 ram_address", ram_address, 7);
      check("read7 ram_wren", ram_wren, 0);
      tick();
      a_req = 0;
      #1;
      check("read7 a_valid", a_valid, 1);
      check("read7 a_q", a_q, 0);
`else
      // No sweep: A read of addr 0 granted in the first cycle after reset.
      a_req = 1; a_wren = 0; a_addr = 0;
      #1;
      check("nosweep busy", busy, 0);
      check("read0 a_gnt", a_gnt, 1);
      check("read0 ram_address", ram_address, 0);
      tick();
      a_req = 0;
      #1;
      check("read0 a_valid", a_valid, 1);
      check("nosweep busy later", busy, 0);
`endif

      // A write 101 to addr 5, then read it back.
      tick();
      a_req = 1; a_wren = 1; a_addr = 5; a_data = 3'b101;
      #1;
      check("wr a_gnt", a_gnt, 1);
      check("wr ram_wren", ram_wren, 1);
      check("wr ram_address", ram_address, 5);
      check("wr ram_data", ram_data, 3'b101);
      tick();
      a_wren = 0; a_data = 0;
      #1;
      check("rd a_gnt", a_gnt, 1);
      check("rd ram_wren", ram_wren, 0);
      check("wr a_valid", a_valid, 1);
      check("wr a_q", a_q, 3'b101);
      tick();
      a_req = 0;
      #1;
      check("rd a_valid", a_valid, 1);
      check("rd a_q", a_q, 3'b101);
      check("idle a_gnt", a_gnt, 0);
      check("idle ram_wren", ram_wren, 0);
      check("idle b_valid", b_valid, 0);
      tick();
      #1;
      check("hold a_valid", a_valid, 0);
      check("hold a_q", a_q, 3'b101);
      check("hold ram_address", ram_address, 5);
      check("hold b_q", b_q, 0);

      // Contention from reset: A reads 2, B writes 110 to 1; expect A,B,A,B.
      do_reset();
      a_req = 1; a_wren = 0; a_addr = 2;
      b_req = 1; b_wren = 1; b_addr = 1; b_data = 3'b110;
      #1;
      check("c0 a_gnt", a_gnt, 1);
      check("c0 b_gnt", b_gnt, 0);
      tick();
      #1;
      check("c1 a_gnt", a_gnt, 0);
      check("c1 b_gnt", b_gnt, 1);
      check("c1 ram_wren", ram_wren, 1);
      check("c1 a_valid", a_valid, 1);
      tick();
      #1;
      check("c2 a_gnt", a_gnt, 1);
      check("c2 b_gnt", b_gnt, 0);
      check("c2 b_valid", b_valid, 1);
      check("c2 b_q", b_q, 3'b110);
      tick();
      #1;
      check("c3 a_gnt", a_gnt, 0);
      check("c3 b_gnt", b_gnt, 1);
      tick();
      idle_inputs();
      #1;
      check("c4 b_valid", b_valid, 1);
      check("c4 b_q", b_q, 3'b110);
      check("c4 a_valid", a_valid, 0);
      check("c4 gnt none", {a_gnt, b_gnt}, 2'b00);

      // B granted, reset the next cycle: no new grant, valid dropped afterwards.
      tick();
      b_req = 1; b_wren = 0; b_addr = 1;
      #1;
      check("rb b_gnt", b_gnt, 1);
      check("rb ram_address", ram_address, 1);
      tick();
      reset = 1;
      #1;
      check("rb reset b_gnt", b_gnt, 0);
      check("rb reset ram_wren", ram_wren, 0);
      check("rb prior b_valid", b_valid, 1);
      tick();
      reset = 0;
      b_req = 0;
      #1;
      check("rb dropped b_valid", b_valid, 0);
`ifdef RAM_CLEAR_EN
      check("rb busy", busy, 1);
      for (int i = 0; i < 32; i++) tick();
`endif

      // Leave the pointer at B, then reset: pointer must return to A.
      a_req = 1; a_wren = 0; a_addr = 3;
      #1;
      check("pa a_gnt", a_gnt, 1);
      tick();
      a_req = 0;
      do_reset();
      a_req = 1; b_req = 1; b_wren = 0; b_addr = 4;
      #1;
      check("ptr a_gnt", a_gnt, 1);
      check("ptr b_gnt", b_gnt, 0);
      tick();
      #1;
      check("ptr2 b_gnt", b_gnt, 1);
      check("ptr2 a_gnt", a_gnt, 0);
      tick();
      idle_inputs();

`ifdef RAM_CLEAR_EN
      // Reset at cycle 10 of the sweep restarts it for a full 32 cycles.
      reset = 1;
      tick();
      tick();
      reset = 0;
      for (int i = 0; i < 10; i++) tick();
      #1;
      check("mid ram_address", ram_address, 10);
      reset = 1;
      tick();
      reset = 0;
      #1;
      check("restart ram_address", ram_address, 0);
      begin
         int busy_cycles;
         busy_cycles = 0;
         while (busy === 1'b1 && busy_cycles < 40) begin
            busy_cycles++;
            tick();
            #1;
         end
         check("restart busy cycles", busy_cycles, 32);
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
